io_output_port: RTL and testbench
=================================

Name: io_output_port

Overview:
- Output-direction counterpart of the processor's IO input path (the input path delivers DataIO to the writeback selector).
- An OUT instruction hands a 32-bit register value to this block, which buffers it in a small FIFO and delivers it to the external output device (display/LED driver) over a valid/ready handshake.
- Asserts Stall toward the pipeline control when the buffer cannot accept a word.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DATA_W, 32, word width.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- OutEnable  input  1  CPU issues an OUT this cycle.
- OutData  input  DATA_W  value to output (register read data).
- Stall  output  1  buffer full; CPU must hold the OUT instruction.
- DevData  output  DATA_W  word presented to the device.
- DevValid  output  1  DevData holds a valid word.
- DevReady  input  1  device accepts DevData this cycle.
- Pending  output  log2(DEPTH)+1  current FIFO occupancy.
- OutCount  output  CNT_W  number of words delivered since reset.

Behaviour:
- Reset, asynchronous: all of the following clear immediately.
  - Read/write pointers and occupancy go to 0.
  - Storage entries go to 0.
  - Stall=0, DevValid=0, DevData=0, Pending=0, OutCount=0.
  - Reset mid-handshake discards all buffered words. No partial delivery is counted.
- Push: OutEnable && !Stall at a rising edge.
  - Writes OutData at the write pointer.
  - Write pointer increments modulo DEPTH.
- Push attempted while Stall=1 is ignored. The CPU re-presents the same OUT next cycle.
- Pop: DevValid && DevReady at a rising edge.
  - Read pointer increments modulo DEPTH.
  - OutCount increments, wrapping from 2^CNT_W-1 to 0.
- Stall = (occupancy == DEPTH). It is a function of registered occupancy only, with no combinational path from DevReady.
  - Consequence: a push while full is rejected even if a pop occurs the same cycle.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged. Both pointers advance.
- Push while empty: the word appears on DevData with DevValid=1 in the cycle after the push edge (1-cycle latency). No same-cycle bypass.
- Device-side FSM, two states:
  - IDLE: DevValid=0. Go to SEND when occupancy becomes nonzero.
  - SEND: DevValid=1; DevData = entry at the read pointer.
  - On pop: stay in SEND if remaining occupancy > 0, otherwise go to IDLE.
- Handshake rules:
  - Once DevValid=1, DevData must stay stable and DevValid must stay high until a DevReady edge completes the transfer.
  - DevReady while DevValid=0 has no effect.
- Pointer wrap: DEPTH consecutive pushes and pops return both pointers to 0. Data order is strictly FIFO.
- Pending equals occupancy. It is registered and updates at the same edges as the pointers.

Test Plan:
- Reset, then one OUT of 0x0000_00A5 with DevReady=1 → DevValid=1 with DevData=0x0000_00A5 one cycle later. Pop next edge, OutCount=1, Pending=0, back to IDLE.
- DevReady=0, five back-to-back OUTs of 1,2,3,4,5 → Pending reaches 4, Stall=1 on the cycle after the fourth push, word 5 not stored. Raise DevReady → words delivered in order 1,2,3,4. Re-present 5 after Stall drops → delivered fifth, OutCount=5.
- FIFO full, DevReady=1 and OutEnable=1 on the same edge → pop accepted, push rejected, Pending=3, Stall=0 next cycle.
- Occupancy 2, push 0xDEAD_BEEF and pop on the same edge → Pending stays 2. DevData advances to the next word. 0xDEAD_BEEF is delivered last.
- DevValid=1 with DevData=0x1234, DevReady held low 10 cycles → DevData and DevValid unchanged for all 10 cycles.
- Assert reset asynchronously between edges while Pending=3 → all outputs 0 immediately. After release, the first new OUT of 0x7 is the first word delivered.

Source files
------------

// File: rtl/io_output_port.sv
// Output-direction IO port: buffers OUT words in a small FIFO and hands them to the
// output device over valid/ready. 1-cycle push-to-valid latency; Stall asserts when full.
module io_output_port #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     OutEnable,
  input  logic [DATA_W-1:0]        OutData,
  output logic                     Stall,
  output logic [DATA_W-1:0]        DevData,
  output logic                     DevValid,
  input  logic                     DevReady,
  output logic [$clog2(DEPTH):0]   Pending,
  output logic [CNT_W-1:0]         OutCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [PW-1:0]    OCC_ONE = PW'(1);
  localparam logic [PW-1:0]    OCC_FULL = PW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [PW-1:0]     occ;
  logic [PW-1:0]     occ_next;
  logic [0:0]        state;
  logic [0:0]        state_next;
  logic [CNT_W-1:0]  out_count;
  logic              full;
  logic              push;
  logic              pop;

  // Full is taken from registered occupancy only, so a same-cycle pop never frees a slot.
  assign full = (occ == OCC_FULL);
  assign push = OutEnable && !full;
  assign pop  = (state == SEND) && DevReady;

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + OCC_ONE;
      2'b01:   occ_next = occ - OCC_ONE;
      default: occ_next = occ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (occ_next != '0) state_next = SEND;
      SEND:    if (pop && occ_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= OutData;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      state     <= IDLE;
      out_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        out_count <= out_count + CNT_ONE;
      end
      occ   <= occ_next;
      state <= state_next;
    end
  end

  assign Stall    = full;
  assign DevValid = (state == SEND);
  assign DevData  = (state == SEND) ? mem[rd_ptr] : '0;
  assign Pending  = occ;
  assign OutCount = out_count;

endmodule

// File: tb/tb_io_output_port.sv
// Bench for io_output_port: directed scenarios plus random traffic against a queue model.
module tb_io_output_port;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clock;
  logic              reset;
  logic              OutEnable;
  logic [DATA_W-1:0] OutData;
  logic              Stall;
  logic [DATA_W-1:0] DevData;
  logic              DevValid;
  logic              DevReady;
  logic [2:0]        Pending;
  logic [CNT_W-1:0]  OutCount;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mq[$];
  logic [CNT_W-1:0]  mcnt;

  io_output_port #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .OutEnable(OutEnable),
    .OutData  (OutData),
    .Stall    (Stall),
    .DevData  (DevData),
    .DevValid (DevValid),
    .DevReady (DevReady),
    .Pending  (Pending),
    .OutCount (OutCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : 32'h0;
    chk({tag, ".Stall"},    32'(Stall),    32'(mq.size() == DEPTH));
    chk({tag, ".DevValid"}, 32'(DevValid), 32'(mq.size() > 0));
    chk({tag, ".DevData"},  DevData,       exp_data);
    chk({tag, ".Pending"},  32'(Pending),  32'(mq.size()));
    chk({tag, ".OutCount"}, 32'(OutCount), 32'(mcnt));
  endtask

  // One clock: the model decides push/pop from pre-edge state, then outputs are checked.
  task automatic cycle(input string tag);
    bit do_push;
    bit do_pop;
    do_push = OutEnable && (mq.size() < DEPTH);
    do_pop  = DevReady && (mq.size() > 0);
    @(posedge clock);
    if (do_pop) begin
      void'(mq.pop_front());
      mcnt++;
    end
    if (do_push) mq.push_back(OutData);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    mq.delete();
    mcnt = '0;
    #1;
    check_model(tag);
    @(negedge clock);
    reset     = 1'b0;
    OutEnable = 1'b0;
    DevReady  = 1'b0;
    OutData   = '0;
  endtask

  initial begin
    reset     = 1'b1;
    OutEnable = 1'b0;
    OutData   = '0;
    DevReady  = 1'b0;
    mcnt      = '0;
    #3;
    check_model("reset");
    @(negedge clock);
    reset = 1'b0;

    // Single word, device ready
    OutEnable = 1'b1; OutData = 32'h0000_00A5; DevReady = 1'b1;
    cycle("t1_push");
    OutEnable = 1'b0;
    chk("t1_valid", 32'(DevValid), 32'd1);
    chk("t1_data", DevData, 32'h0000_00A5);
    cycle("t1_pop");
    chk("t1_count", 32'(OutCount), 32'd1);
    chk("t1_pending", 32'(Pending), 32'd0);
    chk("t1_idle", 32'(DevValid), 32'd0);

    // Fill to full, fifth word rejected, then drain in order
    do_reset("t2_rst");
    for (int i = 1; i <= 5; i++) begin
      OutEnable = 1'b1; OutData = 32'(i);
      cycle("t2_fill");
      if (i == 4) chk("t2_stall4", 32'(Stall), 32'd1);
    end
    chk("t2_pending4", 32'(Pending), 32'd4);
    OutEnable = 1'b0; DevReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", DevData, 32'(i));
      cycle("t2_drain");
    end
    OutEnable = 1'b1; OutData = 32'd5;
    cycle("t2_repush");
    OutEnable = 1'b0;
    chk("t2_word5", DevData, 32'd5);
    cycle("t2_last");
    chk("t2_count", 32'(OutCount), 32'd5);

    // Full with simultaneous pop and push: push rejected
    do_reset("t3_rst");
    for (int i = 0; i < 4; i++) begin
      OutEnable = 1'b1; OutData = 32'h10 + 32'(i);
      cycle("t3_fill");
    end
    DevReady = 1'b1; OutData = 32'h99;
    cycle("t3_both");
    OutEnable = 1'b0; DevReady = 1'b0;
    chk("t3_pending", 32'(Pending), 32'd3);
    chk("t3_stall", 32'(Stall), 32'd0);
    chk("t3_data", DevData, 32'h11);

    // Occupancy 2 with simultaneous push and pop
    do_reset("t4_rst");
    OutEnable = 1'b1; OutData = 32'hA;
    cycle("t4_a");
    OutData = 32'hB;
    cycle("t4_b");
    OutData = 32'hDEAD_BEEF; DevReady = 1'b1;
    cycle("t4_both");
    OutEnable = 1'b0;
    chk("t4_pending", 32'(Pending), 32'd2);
    chk("t4_next", DevData, 32'hB);
    cycle("t4_d1");
    chk("t4_last", DevData, 32'hDEAD_BEEF);
    cycle("t4_d2");
    chk("t4_empty", 32'(DevValid), 32'd0);

    // Holding valid while device stalls
    do_reset("t5_rst");
    OutEnable = 1'b1; OutData = 32'h1234;
    cycle("t5_push");
    OutEnable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle("t5_hold");
      chk("t5_data", DevData, 32'h1234);
      chk("t5_valid", 32'(DevValid), 32'd1);
    end

    // Asynchronous reset with words buffered
    for (int i = 0; i < 2; i++) begin
      OutEnable = 1'b1; OutData = 32'h50 + 32'(i);
      cycle("t6_fill");
    end
    OutEnable = 1'b0;
    chk("t6_pending3", 32'(Pending), 32'd3);
    do_reset("t6_async");
    chk("t6_data0", DevData, 32'd0);
    OutEnable = 1'b1; OutData = 32'h7; DevReady = 1'b1;
    cycle("t6_push");
    OutEnable = 1'b0;
    chk("t6_first", DevData, 32'h7);
    cycle("t6_pop");
    chk("t6_count", 32'(OutCount), 32'd1);

    // Random traffic against the queue model
    for (int i = 0; i < 500; i++) begin
      OutEnable = ($urandom_range(0, 99) < 60);
      OutData   = $urandom;
      DevReady  = ($urandom_range(0, 99) < 45);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
